// File: rtl/gpr_sel_seq_pkg.sv
// Shared types and constants for the GPR select/encode block and its
// block-transfer sequencer.
package gpr_sel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_NUM_REGS = 16;
    localparam int MAX_REGS     = 32;
    localparam int DEF_IR_W     = 32;
    localparam int RA_LSB       = 23;
    localparam int RB_LSB       = 19;
    localparam int RC_LSB       = 15;

    // Full-width one-hot; callers keep the low NUM_REGS bits.
    function automatic logic [MAX_REGS-1:0] onehot(input logic [4:0] idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/gpr_sel_seq_if.sv
// Control-unit side bundle of the GPR select block: decode controls,
// block-transfer handshake and the register enables it produces.
interface gpr_sel_seq_if #(
    parameter int NUM_REGS = 16,
    parameter int IR_W     = 32
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [IR_W-1:0]     ir;
    logic                gra;
    logic                grb;
    logic                grc;
    logic                rin;
    logic                rout;
    logic                baout;
    logic                start;
    logic [NUM_REGS-1:0] blk_mask;
    logic                blk_dir;
    logic                step_ack;
    logic [NUM_REGS-1:0] gpr_in;
    logic [NUM_REGS-1:0] gpr_out;
    logic                ba_zero;
    logic [IDX_W-1:0]    cur_idx;
    logic                busy;
    logic                done;

    modport master (
        output ir, gra, grb, grc, rin, rout, baout,
        output start, blk_mask, blk_dir, step_ack,
        input  gpr_in, gpr_out, ba_zero, cur_idx, busy, done
    );

    modport slave (
        input  ir, gra, grb, grc, rin, rout, baout,
        input  start, blk_mask, blk_dir, step_ack,
        output gpr_in, gpr_out, ba_zero, cur_idx, busy, done
    );
endinterface

// File: rtl/gpr_sel_seq_lowest_set_enc.sv
// Priority encoder for the lowest set bit of a register mask: index,
// isolated one-hot and a non-empty flag.
module lowest_set_enc #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0] vec_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic [NUM_REGS-1:0] onehot_o,
    output logic                any_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            idx_o = vec_i[i] ? IDX_W'(i) : idx_o;
        end
    end

    assign onehot_o = vec_i & (~vec_i + NUM_REGS'(1));
    assign any_o    = |vec_i;

endmodule

// File: rtl/gpr_sel_seq.sv
// Registered GPR enable decoder with a block-transfer sequencer that walks
// a register mask one register per acknowledged cycle.
module gpr_sel_seq #(
    parameter int NUM_REGS = gpr_sel_pkg::DEF_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int IR_W     = gpr_sel_pkg::DEF_IR_W,
    parameter int RA_LSB   = gpr_sel_pkg::RA_LSB,
    parameter int RB_LSB   = gpr_sel_pkg::RB_LSB,
    parameter int RC_LSB   = gpr_sel_pkg::RC_LSB
) (
    input  logic          clk,
    input  logic          clr,
    gpr_sel_seq_if.slave  bus
);
    import gpr_sel_pkg::*;

    state_e              state_q, state_d;
    logic [NUM_REGS-1:0] pend_q, pend_d, pend_clr_s;
    logic                dir_q, dir_d;

    logic [IDX_W-1:0]    field_s;
    logic                field_vld_s;
    logic [MAX_REGS-1:0] field_oh_full_s;
    logic [NUM_REGS-1:0] field_oh_s;
    logic [NUM_REGS-1:0] sin_s, sout_s;
    logic                ba_r0_s;

    logic [IDX_W-1:0]    nxt_idx_s;
    logic [NUM_REGS-1:0] nxt_oh_s;
    logic                nxt_any_s;

    logic [NUM_REGS-1:0] gpr_in_q, gpr_in_d;
    logic [NUM_REGS-1:0] gpr_out_q, gpr_out_d;
    logic                ba_zero_q, ba_zero_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                unused_s;

    // Field mux: gra beats grb beats grc.
    always_comb begin
        field_s     = '0;
        field_vld_s = 1'b0;
        if (bus.gra) begin
            field_s     = bus.ir[RA_LSB +: IDX_W];
            field_vld_s = 1'b1;
        end else if (bus.grb) begin
            field_s     = bus.ir[RB_LSB +: IDX_W];
            field_vld_s = 1'b1;
        end else if (bus.grc) begin
            field_s     = bus.ir[RC_LSB +: IDX_W];
            field_vld_s = 1'b1;
        end else begin
            field_vld_s = 1'b0;
        end
    end

    assign field_oh_full_s = onehot(5'(field_s));
    assign field_oh_s      = field_oh_full_s[NUM_REGS-1:0];
    assign unused_s        = ^{bus.ir, field_oh_full_s};

    // Single-mode decode; baout on R0 reads a constant zero instead of R0.
    always_comb begin
        sin_s   = '0;
        sout_s  = '0;
        ba_r0_s = 1'b0;
        if (field_vld_s) begin
            ba_r0_s = bus.baout && (field_s == '0);
            if (bus.rin) sin_s = field_oh_s;
            else         sin_s = '0;
            if (bus.rout || (bus.baout && !ba_r0_s)) sout_s = field_oh_s;
            else                                      sout_s = '0;
        end else begin
            ba_r0_s = 1'b0;
        end
    end

    assign pend_clr_s = pend_q & (pend_q - NUM_REGS'(1));

    // Sequencer next state and pending mask.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pend_d  = bus.blk_mask;
                    dir_d   = bus.blk_dir;
                    state_d = (|bus.blk_mask) ? RUN : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.step_ack) begin
                    pend_d  = pend_clr_s;
                    state_d = (|pend_clr_s) ? RUN : DONE;
                end else begin
                    pend_d = pend_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                pend_d  = '0;
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
    end

    lowest_set_enc #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_enc (
        .vec_i    (pend_d),
        .idx_o    (nxt_idx_s),
        .onehot_o (nxt_oh_s),
        .any_o    (nxt_any_s)
    );

    // Next output values, looked ahead from the next state so outputs are registered.
    always_comb begin
        gpr_in_d  = '0;
        gpr_out_d = '0;
        ba_zero_d = 1'b0;
        cur_idx_d = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        if ((state_d == RUN) && nxt_any_s) begin
            busy_d    = 1'b1;
            cur_idx_d = nxt_idx_s;
            if (dir_d) gpr_in_d  = nxt_oh_s;
            else       gpr_out_d = nxt_oh_s;
        end else if ((state_q == IDLE) && (state_d == IDLE)) begin
            gpr_in_d  = sin_s;
            gpr_out_d = sout_s;
            ba_zero_d = ba_r0_s;
        end else begin
            done_d = (state_d == DONE);
        end
    end

    // State, mask and output registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            dir_q     <= 1'b0;
            gpr_in_q  <= '0;
            gpr_out_q <= '0;
            ba_zero_q <= 1'b0;
            cur_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            dir_q     <= dir_d;
            gpr_in_q  <= gpr_in_d;
            gpr_out_q <= gpr_out_d;
            ba_zero_q <= ba_zero_d;
            cur_idx_q <= cur_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.gpr_in  = gpr_in_q;
    assign bus.gpr_out = gpr_out_q;
    assign bus.ba_zero = ba_zero_q;
    assign bus.cur_idx = cur_idx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_gpr_sel_seq.sv
// Directed bench for gpr_sel_seq: single-mode decode, block transfers,
// stalls, ignored starts, empty mask and a 32-register instance.
module tb_gpr_sel_seq;

    logic clk = 1'b0;
    logic clr;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gpr_sel_seq_if #(.NUM_REGS(16), .IR_W(32)) b16 ();
    gpr_sel_seq_if #(.NUM_REGS(32), .IR_W(32)) b32 ();

    gpr_sel_seq #(.NUM_REGS(16)) dut16 (.clk(clk), .clr(clr), .bus(b16));
    gpr_sel_seq #(.NUM_REGS(32)) dut32 (.clk(clk), .clr(clr), .bus(b32));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b16.ir = 32'h0; b16.gra = 1'b0; b16.grb = 1'b0; b16.grc = 1'b0;
        b16.rin = 1'b0; b16.rout = 1'b0; b16.baout = 1'b0; b16.start = 1'b0;
        b16.blk_mask = 16'h0; b16.blk_dir = 1'b0; b16.step_ack = 1'b0;
        b32.ir = 32'h0; b32.gra = 1'b0; b32.grb = 1'b0; b32.grc = 1'b0;
        b32.rin = 1'b0; b32.rout = 1'b0; b32.baout = 1'b0; b32.start = 1'b0;
        b32.blk_mask = 32'h0; b32.blk_dir = 1'b0; b32.step_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        clr = 1'b1;
        #2;
        n_vec++;
        if ({b16.gpr_in, b16.gpr_out, b16.ba_zero, b16.cur_idx, b16.busy, b16.done} !== 39'd0) begin
            n_err++; $display("FAIL reset16: outputs=%h expected 0", {b16.gpr_in, b16.gpr_out, b16.ba_zero, b16.cur_idx, b16.busy, b16.done});
        end
        n_vec++;
        if ({b32.gpr_in, b32.gpr_out, b32.ba_zero, b32.cur_idx, b32.busy, b32.done} !== 72'd0) begin
            n_err++; $display("FAIL reset32: outputs=%h expected 0", {b32.gpr_in, b32.gpr_out, b32.ba_zero, b32.cur_idx, b32.busy, b32.done});
        end
        tick();
        clr = 1'b0;
        // mid-transfer reset
        b16.blk_mask = 16'h0F00; b16.blk_dir = 1'b1; b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
        n_vec++;
        if (b16.gpr_in !== 16'h0100 || b16.busy !== 1'b1 || b16.cur_idx !== 4'd8) begin
            n_err++; $display("FAIL run_before_clr: gpr_in=%h busy=%b idx=%0d expected 0100 1 8", b16.gpr_in, b16.busy, b16.cur_idx);
        end
        tick();
        #2 clr = 1'b1;
        #1;
        n_vec++;
        if ({b16.gpr_in, b16.gpr_out, b16.ba_zero, b16.cur_idx, b16.busy, b16.done} !== 39'd0) begin
            n_err++; $display("FAIL async_clr: outputs=%h expected 0", {b16.gpr_in, b16.gpr_out, b16.ba_zero, b16.cur_idx, b16.busy, b16.done});
        end
        tick();
        clr = 1'b0;
        b16.blk_mask = 16'h0001; b16.blk_dir = 1'b0; b16.step_ack = 1'b1; b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
        n_vec++;
        if (b16.gpr_out !== 16'h0001 || b16.busy !== 1'b1) begin
            n_err++; $display("FAIL restart: gpr_out=%h busy=%b expected 0001 1", b16.gpr_out, b16.busy);
        end
        tick();
        n_vec++;
        if (b16.done !== 1'b1 || b16.busy !== 1'b0 || b16.gpr_out !== 16'h0) begin
            n_err++; $display("FAIL restart_done: done=%b busy=%b gpr_out=%h expected 1 0 0000", b16.done, b16.busy, b16.gpr_out);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_single();
        b16.ir = 32'h0280_0000;  // Ra = 5
        b16.gra = 1'b1; b16.rin = 1'b1;
        tick();
        n_vec++;
        if (b16.gpr_in !== 16'h0020 || b16.gpr_out !== 16'h0) begin
            n_err++; $display("FAIL single_rin: gpr_in=%h gpr_out=%h expected 0020 0000", b16.gpr_in, b16.gpr_out);
        end
        b16.gra = 1'b0;
        tick();
        n_vec++;
        if (b16.gpr_in !== 16'h0) begin
            n_err++; $display("FAIL single_nofield: gpr_in=%h expected 0000", b16.gpr_in);
        end
        b16.gra = 1'b1; b16.rout = 1'b1;
        tick();
        n_vec++;
        if (b16.gpr_in !== 16'h0020 || b16.gpr_out !== 16'h0020) begin
            n_err++; $display("FAIL single_both: gpr_in=%h gpr_out=%h expected 0020 0020", b16.gpr_in, b16.gpr_out);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_prio_r0();
        b16.ir = 32'h0003_8000;  // Rb = 0, Rc = 7
        b16.grb = 1'b1; b16.grc = 1'b1; b16.baout = 1'b1;
        tick();
        n_vec++;
        if (b16.gpr_out !== 16'h0 || b16.ba_zero !== 1'b1) begin
            n_err++; $display("FAIL ba_r0: gpr_out=%h ba_zero=%b expected 0000 1", b16.gpr_out, b16.ba_zero);
        end
        b16.baout = 1'b0; b16.rout = 1'b1;
        tick();
        n_vec++;
        if (b16.gpr_out !== 16'h0001 || b16.ba_zero !== 1'b0) begin
            n_err++; $display("FAIL rout_r0: gpr_out=%h ba_zero=%b expected 0001 0", b16.gpr_out, b16.ba_zero);
        end
        b16.grb = 1'b0; b16.rout = 1'b0; b16.baout = 1'b1;
        tick();
        n_vec++;
        if (b16.gpr_out !== 16'h0080 || b16.ba_zero !== 1'b0) begin
            n_err++; $display("FAIL ba_r7: gpr_out=%h ba_zero=%b expected 0080 0", b16.gpr_out, b16.ba_zero);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_block_load();
        logic [15:0] exp_oh  [4] = '{16'h0001, 16'h0002, 16'h0010, 16'h8000};
        logic [3:0]  exp_idx [4] = '{4'd0, 4'd1, 4'd4, 4'd15};
        b16.blk_mask = 16'h8013; b16.blk_dir = 1'b1; b16.step_ack = 1'b1; b16.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            b16.start = 1'b0;
            n_vec++;
            if (b16.gpr_in !== exp_oh[i] || b16.cur_idx !== exp_idx[i] || b16.busy !== 1'b1 ||
                b16.gpr_out !== 16'h0 || b16.done !== 1'b0) begin
                n_err++; $display("FAIL load_step%0d: gpr_in=%h idx=%0d busy=%b gpr_out=%h expected %h %0d 1 0000",
                                  i, b16.gpr_in, b16.cur_idx, b16.busy, b16.gpr_out, exp_oh[i], exp_idx[i]);
            end
        end
        tick();
        n_vec++;
        if (b16.done !== 1'b1 || b16.busy !== 1'b0 || b16.gpr_in !== 16'h0) begin
            n_err++; $display("FAIL load_done: done=%b busy=%b gpr_in=%h expected 1 0 0000", b16.done, b16.busy, b16.gpr_in);
        end
        b16.step_ack = 1'b0;
        tick();
        n_vec++;
        if (b16.done !== 1'b0) begin
            n_err++; $display("FAIL load_done_pulse: done=%b expected 0", b16.done);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        b16.blk_mask = 16'h0006; b16.blk_dir = 1'b0; b16.step_ack = 1'b0; b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
        n_vec++;
        if (b16.gpr_out !== 16'h0002 || b16.cur_idx !== 4'd1 || b16.busy !== 1'b1) begin
            n_err++; $display("FAIL store_first: gpr_out=%h idx=%0d busy=%b expected 0002 1 1", b16.gpr_out, b16.cur_idx, b16.busy);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                b16.start = 1'b1; b16.blk_mask = 16'hFFFF; b16.blk_dir = 1'b1;
            end
            tick();
            b16.start = 1'b0;
            n_vec++;
            if (b16.gpr_out !== 16'h0002 || b16.gpr_in !== 16'h0 || b16.cur_idx !== 4'd1) begin
                n_err++; $display("FAIL stall%0d: gpr_out=%h gpr_in=%h idx=%0d expected 0002 0000 1", i, b16.gpr_out, b16.gpr_in, b16.cur_idx);
            end
        end
        b16.step_ack = 1'b1;
        tick();
        n_vec++;
        if (b16.gpr_out !== 16'h0004 || b16.cur_idx !== 4'd2) begin
            n_err++; $display("FAIL store_second: gpr_out=%h idx=%0d expected 0004 2", b16.gpr_out, b16.cur_idx);
        end
        tick();
        n_vec++;
        if (b16.done !== 1'b1 || b16.gpr_out !== 16'h0) begin
            n_err++; $display("FAIL store_done: done=%b gpr_out=%h expected 1 0000", b16.done, b16.gpr_out);
        end
        b16.start = 1'b1; b16.blk_mask = 16'h0001; b16.blk_dir = 1'b0;
        tick();
        b16.start = 1'b0;
        n_vec++;
        if (b16.busy !== 1'b0 || b16.gpr_out !== 16'h0 || b16.done !== 1'b0) begin
            n_err++; $display("FAIL start_in_done: busy=%b gpr_out=%h done=%b expected 0 0000 0", b16.busy, b16.gpr_out, b16.done);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_empty();
        b16.blk_mask = 16'h0; b16.start = 1'b1;
        tick();
        b16.start = 1'b0;
        n_vec++;
        if (b16.done !== 1'b1 || b16.busy !== 1'b0) begin
            n_err++; $display("FAIL empty_done: done=%b busy=%b expected 1 0", b16.done, b16.busy);
        end
        tick();
        n_vec++;
        if (b16.done !== 1'b0 || b16.busy !== 1'b0) begin
            n_err++; $display("FAIL empty_after: done=%b busy=%b expected 0 0", b16.done, b16.busy);
        end
        idle_inputs();
    endtask

    task automatic test_wide();
        b32.ir = 32'h0A00_0000;  // Ra = 20
        b32.gra = 1'b1; b32.rin = 1'b1;
        tick();
        n_vec++;
        if (b32.gpr_in !== 32'h0010_0000) begin
            n_err++; $display("FAIL wide_single: gpr_in=%h expected 00100000", b32.gpr_in);
        end
        idle_inputs();
        b32.blk_mask = 32'h8000_0000; b32.blk_dir = 1'b0; b32.step_ack = 1'b1; b32.start = 1'b1;
        tick();
        b32.start = 1'b0;
        n_vec++;
        if (b32.gpr_out !== 32'h8000_0000 || b32.cur_idx !== 5'd31 || b32.busy !== 1'b1) begin
            n_err++; $display("FAIL wide_block: gpr_out=%h idx=%0d busy=%b expected 80000000 31 1", b32.gpr_out, b32.cur_idx, b32.busy);
        end
        tick();
        n_vec++;
        if (b32.done !== 1'b1 || b32.gpr_out !== 32'h0) begin
            n_err++; $display("FAIL wide_done: done=%b gpr_out=%h expected 1 00000000", b32.done, b32.gpr_out);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_prio_r0();
        test_block_load();
        test_stall();
        test_empty();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
